// File: rtl/vga_pixel_fetch.sv
// Display-side pixel fetch: issues framebuffer reads, keeps RGB and syncs pixel-aligned, and owns
// the bank-swap handshake. Optional macro VGA_FETCH_THRESH_EN adds a binary threshold on output.
module vga_pixel_fetch #(
  parameter int unsigned IMG_W   = 320,
  parameter int unsigned IMG_H   = 240,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic              vgaClk,
  input  logic              rstN,
  input  logic [9:0]        hCount,
  input  logic [8:0]        vCount,
  input  logic              hSync,
  input  logic              vSync,
  input  logic              syncB,
  input  logic              blankB,
  output logic [ADDR_W:0]   memAddr,
  output logic              memRdEn,
  input  logic [PIX_W-1:0]  memRdData,
`ifdef VGA_FETCH_THRESH_EN
  input  logic [PIX_W-1:0]  threshold,
`endif
  output logic [PIX_W-1:0]  vgaR,
  output logic [PIX_W-1:0]  vgaG,
  output logic [PIX_W-1:0]  vgaB,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              syncBOut,
  output logic              blankBOut,
  input  logic              swapReq,
  output logic              swapAck,
  output logic              rdBank
);

  // Timing bundle layout: {hSync, vSync, syncB, blankB}; idle value has syncs high, rest low.
  localparam logic [3:0] TimingRst = 4'b1100;

  typedef enum logic [1:0] {StIdle, StPend, StAck} swapStateE;

  swapStateE stateQ, stateD;
  logic      vSyncPrevQ;
  logic      vFall;
  logic      doSwap;
  logic      rdBankQ;
  logic      swapAckQ;

  logic              inRange;
  logic [ADDR_W-1:0] offset;

  logic [3:0]       timingPipeQ [MEM_LAT+1];
  logic [3:0]       timingOutQ;
  logic [PIX_W-1:0] pixVal;
  logic [PIX_W-1:0] pixD;
  logic [PIX_W-1:0] pixQ;

  // ---------------- Bank-swap FSM ----------------
  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      stateQ     <= StIdle;
      vSyncPrevQ <= 1'b1;
      rdBankQ    <= 1'b0;
      swapAckQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      vSyncPrevQ <= vSync;
      rdBankQ    <= rdBankQ ^ doSwap;
      swapAckQ   <= doSwap;
    end
  end

  assign vFall = vSyncPrevQ & ~vSync;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (swapReq) stateD = StPend;
      // A dropped request wins over a coincident vsync edge: no swap.
      StPend:  if (!swapReq) stateD = StIdle;
               else if (vFall) stateD = StAck;
      StAck:   if (!swapReq) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    doSwap = (stateQ == StPend) && swapReq && vFall;
  end

  assign rdBank  = rdBankQ;
  assign swapAck = swapAckQ;

  // ---------------- Stage 0: address issue ----------------
  always_comb begin
    inRange = (32'(hCount) < IMG_W) && (32'(vCount) < IMG_H);
    offset  = '0;
    if (inRange) begin
      offset = ADDR_W'(vCount) * ADDR_W'(IMG_W) + ADDR_W'(hCount);
    end
  end

  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      memAddr <= '0;
      memRdEn <= 1'b0;
    end else begin
      memAddr <= {rdBankQ, offset};
      memRdEn <= syncB;
    end
  end

  // ---------------- Timing delay line, MEM_LAT+2 stages total ----------------
  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i <= MEM_LAT; i++) begin
        timingPipeQ[i] <= TimingRst;
      end
      timingOutQ <= TimingRst;
    end else begin
      timingPipeQ[0] <= {hSync, vSync, syncB, blankB};
      for (int unsigned i = 1; i <= MEM_LAT; i++) begin
        timingPipeQ[i] <= timingPipeQ[i-1];
      end
      timingOutQ <= timingPipeQ[MEM_LAT];
    end
  end

  // ---------------- Output stage ----------------
  always_comb begin
`ifdef VGA_FETCH_THRESH_EN
    pixVal = (memRdData >= threshold) ? '1 : '0;
`else
    pixVal = memRdData;
`endif
    // timingPipeQ[MEM_LAT] lines up with the read data arriving this cycle.
    pixD = timingPipeQ[MEM_LAT][1] ? pixVal : '0;
  end

  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      pixQ <= '0;
    end else begin
      pixQ <= pixD;
    end
  end

  assign vgaR      = pixQ;
  assign vgaG      = pixQ;
  assign vgaB      = pixQ;
  assign hSyncOut  = timingOutQ[3];
  assign vSyncOut  = timingOutQ[2];
  assign syncBOut  = timingOutQ[1];
  assign blankBOut = timingOutQ[0];

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Sits directly downstream of the VGA timing generator.
- Consumes folded pixel coordinates (hCount 0..319, vCount 0..239) plus hSync/vSync/syncB/blankB, and issues reads into a double-buffered 320x240 grayscale framebuffer RAM.
- Drives RGB to the DAC with all sync/blank signals delayed to stay pixel-aligned.
- Owns the bank-swap handshake with the edge-detection writer, so the displayed bank only changes at a vertical sync.

Parameters:
- IMG_W, 320, image width in pixels; also the row stride.
- IMG_H, 240, image height in rows.
- PIX_W, 8, grayscale pixel width.
- MEM_LAT, 1, RAM read latency in cycles (rdEn/addr to rdData valid); legal range 1..3.
- ADDR_W, 17, per-bank address width; the full RAM address is ADDR_W+1 bits.

Ports:
- vgaClk  in  1  pixel clock.
- rstN  in  1  asynchronous active-low reset.
- hCount  in  10  folded horizontal coordinate, 0..IMG_W-1.
- vCount  in  9  folded vertical coordinate, 0..IMG_H-1.
- hSync  in  1  active-low hsync from the timing generator.
- vSync  in  1  active-low vsync.
- syncB  in  1  high during the 640x480 visible region.
- blankB  in  1  blank signal from the timing generator.
- memAddr  out  ADDR_W+1  {rdBank, vCount*IMG_W+hCount}.
- memRdEn  out  1  read strobe.
- memRdData  in  PIX_W  RAM read data, valid MEM_LAT cycles after memRdEn.
- vgaR, vgaG, vgaB  out  PIX_W each  pixel output.
- hSyncOut, vSyncOut, syncBOut, blankBOut  out  1 each  delayed copies of the timing inputs.
- swapReq  in  1  writer requests a bank swap; level, held until acknowledged.
- swapAck  out  1  one-cycle pulse when the swap takes effect.
- rdBank  out  1  bank currently being displayed.

Behaviour:
- Reset (rstN low, asynchronous):
  - memAddr=0, memRdEn=0, RGB=0.
  - hSyncOut=1, vSyncOut=1, syncBOut=0, blankBOut=0.
  - swapAck=0, rdBank=0, FSM in IDLE.
  - All pipeline stages are cleared to these same values.
- Stage 0, registered on vgaClk:
  - memAddr <= {rdBank, vCount*IMG_W + hCount}, computed at full width with no truncation.
  - memRdEn <= syncB.
  - Coordinates outside range (hCount>=IMG_W or vCount>=IMG_H) clamp the offset to 0.
- Stage 1..MEM_LAT: memRdData becomes valid.
- Final output register:
  - RGB <= memRdData on all three channels if the delayed syncB is 1; otherwise RGB <= 0.
- Total latency from input timing to RGB and the delayed syncs is MEM_LAT+2 cycles.
  - hSync, vSync, syncB and blankB pass through a shift register of exactly this depth, so outputs stay coherent.
- Swap FSM states:
  - IDLE: when swapReq=1, go to PEND.
  - PEND: on a vSync falling edge (registered previous value 1, current 0), toggle rdBank, drive swapAck=1 for one cycle, go to ACK.
  - ACK: remain until swapReq=0, then go to IDLE. This makes the handshake four-phase; a held request never double-swaps.
- rdBank changes only at a vSync falling edge, never mid-frame.
  - The new bank is used for the first address issued after the edge.
- If swapReq drops while in PEND, return to IDLE with no swap.
- swapReq rising in the same cycle as a vSync falling edge:
  - Enters PEND only.
  - The swap occurs at the next frame's vSync edge, not this one.
- Reset mid-frame or mid-handshake: FSM returns to IDLE and rdBank to 0. The writer must re-request.

Optional Feature:
- Macro: VGA_FETCH_THRESH_EN.
- When defined:
  - Adds input threshold [PIX_W-1:0].
  - In the output stage, an active pixel becomes all-ones if memRdData >= threshold, else 0.
  - threshold is sampled in the final stage with no extra latency.
- When undefined: the port is absent and pixels pass through unmodified.

Test Plan:
- Reset:
  - Stimulus: hold rstN=0 with syncB=1 and swapReq=1, then release.
  - Response: all outputs at their reset values, rdBank=0, swapAck=0.
- Address formula:
  - Stimulus: hCount=5, vCount=2, syncB=1.
  - Response: memAddr=0x00285 (645) with memRdEn=1 one cycle later; hCount=319, vCount=239 gives 76799.
- Latency (MEM_LAT=1):
  - Stimulus: RAM model returns 0xA5.
  - Response: RGB=0xA5A5A5 exactly 3 cycles after the coordinate; hSyncOut equals hSync delayed 3 cycles.
- Blanking:
  - Stimulus: syncB=0 with memRdData=0xFF.
  - Response: RGB=0 and memRdEn=0.
- Swap:
  - Stimulus: swapReq=1 at mid-frame line 100.
  - Response: no change until the vSync falling edge; then rdBank 0->1, one swapAck pulse, next memAddr MSB=1. Holding swapReq for 2 more frames gives no further toggles.
- Threshold (VGA_FETCH_THRESH_EN defined):
  - Stimulus: threshold=0x80, data 0x7F then 0x80.
  - Response: RGB 0x000000 then 0xFFFFFF.
